// File: rtl/scratch_stack_pkg.sv
// rtl/scratch_stack_pkg.sv - shared encodings and default widths for the scratch stack controller
package scratch_stack_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'b00,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b10,
        OP_SWAP    = 2'b11
    } stack_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD1  = 2'b01,
        ST_RD2  = 2'b10,
        ST_WR   = 2'b11
    } stack_state_e;

endpackage

// File: rtl/scratch_stack_mem.sv
// rtl/scratch_stack_mem.sv - single-port synchronous stack RAM with registered read data
//   clk      : clock
//   addr     : cell address
//   din      : write data
//   dout     : read data, registered (valid the cycle after addr is presented)
//   write_en : write din into addr at this edge
module scratch_stack_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    input  logic              write_en
);

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (write_en) begin
            ram[addr] <= din;
        end
        dout <= ram[addr];
    end

endmodule

// File: rtl/scratch_stack_ctrl.sv
// rtl/scratch_stack_ctrl.sv - CPU scratch stack sequencer: cached TOS register over a sync RAM
//   clk, resetn        : clock, asynchronous active-low reset
//   cmd_valid/ready    : command handshake (ready only in IDLE)
//   cmd_op, cmd_data   : 00 PUSH, 01 POP, 10 REPLACE, 11 SWAP; new TOS for PUSH/REPLACE
//   done               : one-cycle completion (or rejection) pulse
//   tos, depth         : cached top of stack, cells held in RAM
//   empty, full, err   : depth==0, depth==DEPTH, rejected command pulse
// Optional feature macro STACK_GUARD_EN: overflow/underflow rejection with full/err driven.
// Without it the stack pointer wraps modulo DEPTH and full/err are tied low.
module scratch_stack_ctrl
    import scratch_stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              done,
    output logic [DATA_W-1:0] tos,
    output logic [ADDR_W:0]   depth,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef STACK_GUARD_EN
    localparam int SP_W = ADDR_W + 1;
`else
    localparam int SP_W = ADDR_W;
`endif

    stack_state_e      state, state_nx;
    stack_op_e         op;
    logic [SP_W-1:0]   sp, sp_m1;
    logic [DATA_W-1:0] tos_q, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen, done_q, swap_q;
    logic              accept, reject;

    assign op    = stack_op_e'(cmd_op);
    assign sp_m1 = sp - SP_W'(1);
    assign tos   = tos_q;
    assign done  = done_q;
    assign empty = (sp == '0);

`ifdef STACK_GUARD_EN
    logic err_q;
    assign depth  = sp;
    assign full   = (sp == SP_W'(DEPTH));
    assign reject = accept && (((op == OP_PUSH) && full) ||
                               (((op == OP_POP) || (op == OP_SWAP)) && empty));
    assign err    = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end
`else
    assign depth  = {1'b0, sp};
    assign full   = 1'b0;
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && !reject) begin
                    case (op)
                        OP_PUSH:           state_nx = ST_WR;
                        OP_POP, OP_SWAP:   state_nx = ST_RD1;
                        default:           state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_RD1:  state_nx = ST_RD2;
            // SWAP must still write the old TOS back; POP is finished here.
            ST_RD2:  state_nx = swap_q ? ST_WR : ST_IDLE;
            ST_WR:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        accept    = cmd_valid && cmd_ready;
    end

    // Datapath registers; done defaults low so it only ever pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tos_q     <= '0;
            sp        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            done_q    <= 1'b0;
            swap_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            done_q <= 1'b1;
                        end else begin
                            case (op)
                                OP_PUSH: begin
                                    mem_addr  <= sp[ADDR_W-1:0];
                                    mem_wdata <= tos_q;
                                    mem_wen   <= 1'b1;
                                    tos_q     <= cmd_data;
                                    sp        <= sp + SP_W'(1);
                                    swap_q    <= 1'b0;
                                end
                                OP_POP: begin
                                    mem_addr <= sp_m1[ADDR_W-1:0];
                                    sp       <= sp_m1;
                                    swap_q   <= 1'b0;
                                end
                                OP_REPLACE: begin
                                    tos_q  <= cmd_data;
                                    done_q <= 1'b1;
                                end
                                default: begin
                                    mem_addr <= sp_m1[ADDR_W-1:0];
                                    swap_q   <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_RD2: begin
                    tos_q <= mem_rdata;
                    if (swap_q) begin
                        mem_wdata <= tos_q;
                        mem_wen   <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                ST_WR: begin
                    mem_wen <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    scratch_stack_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .addr     (mem_addr),
        .din      (mem_wdata),
        .dout     (mem_rdata),
        .write_en (mem_wen)
    );

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// tb/tb_scratch_stack_ctrl.sv - self-checking bench for scratch_stack_ctrl against a stack model
module tb_scratch_stack_ctrl;

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        done;
    logic [31:0] tos;
    logic [8:0]  depth;
    logic        empty;
    logic        full;
    logic        err;

    int tests = 0;
    int fails = 0;

    // Reference model: abstract stack of RAM cells plus a separate TOS value.
    int          m_sp;
    logic [31:0] m_tos;
    logic [31:0] m_mem [256];

    always #5 clk = ~clk;

    scratch_stack_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .done      (done),
        .tos       (tos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [31:0] d,
                             output int lat, output bit rej);
        int          idx;
        logic [31:0] t;
        rej = 1'b0;
        lat = 1;
        case (op)
            2'b00: begin
                if (GUARD && m_sp == 256) rej = 1'b1;
                else begin
                    m_mem[m_sp % 256] = m_tos;
                    m_tos = d;
                    m_sp  = GUARD ? m_sp + 1 : (m_sp + 1) % 256;
                    lat   = 2;
                end
            end
            2'b01: begin
                if (GUARD && m_sp == 0) rej = 1'b1;
                else begin
                    m_sp  = GUARD ? m_sp - 1 : (m_sp + 255) % 256;
                    m_tos = m_mem[m_sp];
                    lat   = 3;
                end
            end
            2'b10: begin
                m_tos = d;
                lat   = 1;
            end
            default: begin
                if (GUARD && m_sp == 0) rej = 1'b1;
                else begin
                    idx        = (m_sp + 255) % 256;
                    t          = m_mem[idx];
                    m_mem[idx] = m_tos;
                    m_tos      = t;
                    lat        = 4;
                end
            end
        endcase
    endtask

    // Called mid-cycle with the DUT idle; returns mid-cycle in the done cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] d, input bit hold);
        int lat_exp;
        bit rej;
        int n;
        bit seen;
        model_cmd(op, d, lat_exp, rej);
        chk("ready_before", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk); #1;
        if (hold) begin
            cmd_op   = op ^ 2'b01;
            cmd_data = ~d;
        end else begin
            cmd_valid = 1'b0;
        end
        n = 1;
        seen = 1'b0;
        while (n <= 8 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                chk("busy_ready", {63'd0, cmd_ready}, 64'd0);
                @(posedge clk); #1;
                n++;
            end
        end
        cmd_valid = 1'b0;
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("latency", 64'(n), 64'(lat_exp));
        chk("err", {63'd0, err}, {63'd0, rej});
        chk("tos", {32'd0, tos}, {32'd0, m_tos});
        chk("depth", {55'd0, depth}, 64'(m_sp));
        chk("empty", {63'd0, empty}, {63'd0, (m_sp == 0)});
        chk("full", {63'd0, full}, {63'd0, (GUARD && m_sp == 256)});
        chk("ready_done", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_pulse", {63'd0, done}, 64'd0);
        chk("err_pulse", {63'd0, err}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        m_sp      = 0;
        m_tos     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tos", {32'd0, tos}, 64'd0);
        chk("rst_depth", {55'd0, depth}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

`ifdef STACK_GUARD_EN
        do_cmd(2'b01, 32'h0, 1'b0);
        do_cmd(2'b11, 32'h0, 1'b0);
        idle_cycle();
`endif

        do_cmd(2'b00, 32'h11, 1'b0);
        do_cmd(2'b00, 32'h22, 1'b0);
        do_cmd(2'b00, 32'h33, 1'b0);
        chk("push3_tos", {32'd0, tos}, 64'h33);
        do_cmd(2'b01, 32'h0, 1'b0);
        do_cmd(2'b01, 32'h0, 1'b0);
        do_cmd(2'b01, 32'h0, 1'b0);
        chk("pop3_tos", {32'd0, tos}, 64'h0);
        idle_cycle();

        do_cmd(2'b00, 32'hA, 1'b0);
        do_cmd(2'b00, 32'hB, 1'b0);
        do_cmd(2'b11, 32'h0, 1'b0);
        chk("swap_tos", {32'd0, tos}, 64'hA);
        do_cmd(2'b01, 32'h0, 1'b0);
        chk("swap_pop_tos", {32'd0, tos}, 64'hB);

        do_cmd(2'b10, 32'hDEAD, 1'b1);
        do_cmd(2'b00, 32'h1234, 1'b1);
        do_cmd(2'b00, 32'h5678, 1'b1);
        do_cmd(2'b11, 32'h0, 1'b1);
        do_cmd(2'b01, 32'h0, 1'b1);
        idle_cycle();

        while (m_sp != 0) do_cmd(2'b01, 32'h0, 1'b0);
        for (int i = 0; i < 256; i++) do_cmd(2'b00, $urandom, 1'b0);
`ifdef STACK_GUARD_EN
        do_cmd(2'b00, 32'hBAD, 1'b0);
        chk("full_after_fill", {63'd0, full}, 64'd1);
`else
        do_cmd(2'b01, 32'h0, 1'b0);
        chk("wrap_depth", {55'd0, depth}, 64'd255);
`endif
        idle_cycle();

        for (int i = 0; i < 150; i++) begin
            do_cmd(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset while a POP is waiting on RAM read data.
        do_cmd(2'b00, 32'h77, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        m_sp  = 0;
        m_tos = '0;
        chk("arst_tos", {32'd0, tos}, 64'd0);
        chk("arst_depth", {55'd0, depth}, 64'd0);
        chk("arst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("arst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_cmd(2'b00, 32'h5, 1'b0);
        chk("post_rst_push", {32'd0, tos}, 64'h5);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scratch_stack_ctrl.md
Name: scratch_stack_ctrl

Overview:
Sequencer owning the CPU scratch (data) stack. It caches top-of-stack (TOS) in a register and holds deeper cells in a synchronous single-port RAM. It accepts one stack command at a time over a valid/ready handshake and hides the RAM's write pulse and two-cycle read wait from the CPU phase machine. It sits between the CPU core and the stack RAM, replacing hand-sequenced stack phases in the core.

Parameters:
DATA_W, 32, cell width
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W RAM cells (TOS is extra)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high iff state==IDLE (combinational)
cmd_op  in  2  00 PUSH, 01 POP, 10 REPLACE, 11 SWAP
cmd_data  in  DATA_W  new TOS value for PUSH/REPLACE
done  out  1  one-cycle pulse when command completes or is rejected
tos  out  DATA_W  cached top of stack
depth  out  ADDR_W+1  cells held in RAM (excludes TOS)
empty  out  1  depth==0
full  out  1  depth==DEPTH (tied 0 without guard)
err  out  1  one-cycle pulse with done on rejected command (tied 0 without guard)

Behaviour:
- Reset (async, any state, including mid-command): state IDLE, tos=0, sp=0, done=0, err=0, internal mem_wen=0. RAM contents are not cleared. An in-flight command is abandoned.
- Accept on rising edge with cmd_valid && cmd_ready (edge E0). cmd_valid is ignored while busy. Inputs are sampled only at E0.
- RAM: registered read. Address registered at Ek gives rdata after Ek+1. Write occurs at the edge where mem_wen=1.
- PUSH:
  - E0: mem_addr<=sp, mem_wdata<=tos, mem_wen<=1, tos<=cmd_data, sp++, ->WR.
  - E1: mem_wen<=0, done<=1, ->IDLE.
- POP:
  - E0: mem_addr<=sp-1, sp--, ->RD1.
  - E1: ->RD2.
  - E2: tos<=rdata, done<=1, ->IDLE.
- REPLACE: E0: tos<=cmd_data, done<=1. Stays IDLE; no RAM access.
- SWAP: exchanges TOS with RAM[sp-1]; sp unchanged.
  - E0: mem_addr<=sp-1, ->RD1.
  - E1: ->RD2.
  - E2: tos<=rdata, mem_wdata<=old tos, mem_wen<=1, ->WR.
  - E3: mem_wen<=0, done, ->IDLE.
- Latency, accept edge to done visible: REPLACE 1, PUSH 2, POP 3, SWAP 4 cycles. Next accept is possible on the edge after done rises (cmd_ready is high during the done cycle).
- tos updates at the edges stated above; the PUSH value is visible from the cycle after E0.
- States: IDLE, RD1, RD2, WR. A SWAP flag distinguishes the WR entry from RD2.

Optional Feature:
STACK_GUARD_EN
- Defined: sp is ADDR_W+1 bits. PUSH when full, or POP/SWAP when empty, is rejected at E0: done=1, err=1, no state or RAM change, stays IDLE. full is driven.
- Undefined: sp is ADDR_W bits and wraps modulo DEPTH. depth = zero-extended sp. full and err are tied 0. POP at sp=0 reads RAM[DEPTH-1] and sp becomes DEPTH-1.

Decomposition:
- Package scratch_stack_pkg: cmd_op encodings (OP_PUSH, OP_POP, OP_REPLACE, OP_SWAP), state encoding, default widths.
- Sub-module scratch_stack_mem: single-port sync RAM, ports clk/addr/din/dout/write_en, DATA_W×DEPTH, registered dout. Instantiated once.

Test Plan:
- Reset, then PUSH 0x11, PUSH 0x22, PUSH 0x33 -> tos=0x33, depth=3, done 2 cycles after each accept. POP ×3 -> tos 0x22, 0x11, 0x0 (reset TOS); depth 0; each done 3 cycles after accept.
- PUSH 0xA, PUSH 0xB, SWAP -> tos=0xA, depth=2, done 4 cycles after accept. POP -> tos=0xB.
- REPLACE 0xDEAD with cmd_valid held high continuously -> done on the next cycle, tos=0xDEAD, depth unchanged. Back-to-back PUSHes accepted every 2 cycles; cmd_valid during RD1/RD2/WR is ignored.
- Guard on: POP at depth 0 -> done+err same cycle, tos/depth unchanged. Fill 256 PUSHes, then PUSH -> err, full=1. Guard off: POP at depth 0 -> depth=255, tos=RAM[255].
- Deassert resetn during a POP's RD2 -> asynchronously tos=0, depth=0, cmd_ready=1. After release, PUSH 0x5 completes normally.
